// File: rtl/decoder3to8_strobe.sv
// Registered 3-to-8 decoder: queued {en, idx} requests become one-hot strobes held PULSE_LEN cycles.
// Optional macro DECODER_GAP_EN inserts one all-zero GAP cycle after every strobe.
module decoder3to8_strobe #(
    parameter int PULSE_LEN = 4,
    parameter int DEPTH     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               in_idx,
    input  logic                     in_en,
    output logic [7:0]               out,
    output logic                     out_active,
    output logic                     strobe_done,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [7:0] CNT_LOAD = 8'(PULSE_LEN - 1);

    typedef struct packed {
        logic       en;
        logic [2:0] idx;
    } req_t;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE
`ifdef DECODER_GAP_EN
        , GAP
`endif
    } state_t;

    // NOTE: the request storage has no reset; entries are only read once count says they are valid.
    req_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          live;
    state_t        state;
    logic [7:0]    cnt;

    logic full;
    logic empty;
    logic push;
    logic pop;
    logic last;
    req_t head;

    function automatic logic [7:0] decode(input req_t r);
        return r.en ? (8'b1 << r.idx) : 8'h00;
    endfunction

    // live holds in_ready low through reset and rises on the first edge with rst released.
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = live && !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    assign last     = (state == DRIVE) && (cnt == 8'd0);
    assign level    = count;

    // NOTE: pop is assigned a default first so every path through the case drives it (no latch).
    always_comb begin
        pop = 1'b0;
        case (state)
            IDLE:    pop = !empty;
`ifdef DECODER_GAP_EN
            GAP:     pop = !empty;
`else
            DRIVE:   pop = last && !empty;
`endif
            default: pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= req_t'{en: in_en, idx: in_idx};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            live   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A pop always loads the head entry, whichever state it is issued from.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out         <= 8'h00;
            out_active  <= 1'b0;
            strobe_done <= 1'b0;
            cnt         <= 8'd0;
        end else if (pop) begin
            state       <= DRIVE;
            out         <= decode(head);
            out_active  <= 1'b1;
            cnt         <= CNT_LOAD;
            strobe_done <= (CNT_LOAD == 8'd0);
        end else begin
            case (state)
                DRIVE: begin
                    if (cnt != 8'd0) begin
                        cnt         <= cnt - 8'd1;
                        strobe_done <= (cnt == 8'd1);
                    end else begin
`ifdef DECODER_GAP_EN
                        state <= GAP;
`else
                        state <= IDLE;
`endif
                        out         <= 8'h00;
                        out_active  <= 1'b0;
                        strobe_done <= 1'b0;
                    end
                end
`ifdef DECODER_GAP_EN
                GAP:     state <= IDLE;
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/decoder3to8_strobe.md
Name: decoder3to8_strobe

Overview:
Registered 3-to-8 decoder. It is the receive-side counterpart of the 8-to-3 priority encoder: it turns an encoded index plus valid flag back into a one-hot strobe on an 8-bit line bus. Requests enter through a valid/ready handshake and wait in a small FIFO. Each request drives a one-hot strobe for PULSE_LEN cycles, so an encoder at the far end sees one clean, isolated line at a time.

Parameters:
PULSE_LEN, 4, number of cycles each one-hot strobe is held; legal range 1..255.
DEPTH, 4, request FIFO depth in entries; power of two, minimum 2.

Ports:
clk  input  1  single rising-edge clock.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  request present.
in_ready  output  1  FIFO can accept a request.
in_idx  input  3  encoded line index, 0..7.
in_en  input  1  request valid flag; 0 means a "no line" request that produces an all-zero strobe.
out  output  8  one-hot strobe; bit in_idx is high while the strobe is driven.
out_active  output  1  high for every cycle a request is being driven, including all-zero requests.
strobe_done  output  1  one-cycle pulse on the last driven cycle of each request.
level  output  $clog2(DEPTH)+1  number of queued requests, not counting the one being driven.

Behaviour:
- Reset:
  - Reset is synchronous and active-high, sampled on the rising edge of clk.
  - out=0, out_active=0, strobe_done=0, level=0, FIFO empty, FSM in IDLE, pulse counter cleared.
  - in_ready=0 while rst is high. in_ready=1 on the first cycle after rst is released.
  - Asserting rst mid-strobe aborts the strobe. Queued requests are discarded. No strobe_done is issued.
- Handshake:
  - A request is accepted on an edge where in_valid && in_ready.
  - in_ready = !full, computed from registered state only.
  - While full, a push is refused even if a pop occurs on the same edge.
  - A push and a pop on the same edge leave level unchanged.
  - in_idx and in_en are captured into the FIFO at acceptance.
- FSM states: IDLE, DRIVE, plus GAP (only when the optional feature is compiled in).
- IDLE:
  - If the FIFO is non-empty, pop the head on the next edge.
  - Load out = in_en ? (8'b1 << in_idx) : 8'h00, set out_active=1, load the counter with PULSE_LEN-1, go to DRIVE.
- DRIVE:
  - out is held constant; the counter decrements each cycle.
  - On the cycle the counter reads 0, assert strobe_done=1 for that cycle only.
  - On that cycle's closing edge: if the FIFO is non-empty, load the next entry directly (back-to-back, no idle cycle) and stay in DRIVE. Otherwise clear out and out_active and go to IDLE.
- Latency:
  - Request accepted at edge E0 into an empty FIFO with FSM in IDLE: out is valid after edge E1 and held through edge E1+PULSE_LEN.
  - With PULSE_LEN=1, every cycle is a last cycle, so strobe_done is high on every driven cycle.
- out is always one-hot or zero, never multi-hot, including across back-to-back transitions. This is guaranteed because out is a single register.
- FIFO pointers are log2(DEPTH) bits and wrap modulo DEPTH. level saturates at DEPTH by construction.

Optional Feature:
Macro name: DECODER_GAP_EN.
- Defined: after each DRIVE, the FSM always passes through GAP for exactly one cycle with out=0 and out_active=0. It then pops the next entry (GAP→DRIVE) or returns to IDLE. This guarantees an all-zero cycle between strobes, so a downstream priority encoder sees valid=0 between lines.
- Not defined: the GAP state and its logic are absent, and back-to-back strobes are contiguous as described in Behaviour.

Test Plan:
1. Reset, then push idx=5, en=1 (PULSE_LEN=4) → out=8'b00100000 for exactly 4 cycles starting one edge after acceptance; strobe_done high on cycle 4; then out=0 and out_active=0.
2. Push idx=0, en=0 → out=8'h00 with out_active=1 for 4 cycles, and strobe_done pulses once.
3. Push idx 1,2,3 back-to-back, gap macro not defined → out sequence 02,02,02,02,04,04,04,04,08,08,08,08 with no zero cycle between strobes; 3 strobe_done pulses.
4. Same stimulus as scenario 3 with DECODER_GAP_EN defined → exactly one cycle of out=0 and out_active=0 between each pair of strobes; total 14 cycles before final idle.
5. Hold in_valid high while pushing 6 requests with DEPTH=4 → in_ready drops when level=4; the refused request is accepted later; all 6 indices appear in order (FIFO wrap exercised).
6. Assert rst during cycle 2 of a strobe with 2 requests queued → out=0, level=0, and in_ready=0 on the next cycle; no further strobes and no strobe_done.
